// File: rtl/sd_read_arbiter_pkg.sv
// sd_pkg: shared types and constants for the SD single-block-read arbiter.
//   arb_state_t  - arbiter FSM states
//   SD_CMD17     - SD READ_SINGLE_BLOCK command index, the command the shared engine issues
//   SD_ADDR_W    - block address width
//   SD_DATA_W    - width of the word returned by the engine
package sd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } arb_state_t;

    localparam logic [7:0] SD_CMD17  = 8'h51;
    localparam int         SD_ADDR_W = 32;
    localparam int         SD_DATA_W = 32;

endpackage

// File: rtl/sd_read_arbiter_if.sv
// sd_read_arbiter_if: requester-side and engine-side signals of the arbiter.
//   req/req_addr      requester read requests (level) and flattened addresses
//   ack/rsp_data/err  one-hot completion pulse, read word, abort flag
//   busy              arbiter not idle
//   rd_start/rd_addr  level start and address toward the single-block-read engine
//   rd_data/rd_done   engine read word and level completion
// Modports: slave = arbiter view, master = environment (requesters + engine) view.
interface sd_read_arbiter_if #(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0]                  req;
    logic [N_REQ*sd_pkg::SD_ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]                  ack;
    logic [sd_pkg::SD_DATA_W-1:0]      rsp_data;
    logic                              rsp_err;
    logic                              busy;
    logic                              rd_start;
    logic [sd_pkg::SD_ADDR_W-1:0]      rd_addr;
    logic [sd_pkg::SD_DATA_W-1:0]      rd_data;
    logic                              rd_done;

    modport slave (
        input  req, req_addr, rd_data, rd_done,
        output ack, rsp_data, rsp_err, busy, rd_start, rd_addr
    );

    modport master (
        output req, req_addr, rd_data, rd_done,
        input  ack, rsp_data, rsp_err, busy, rd_start, rd_addr
    );

endinterface

// File: rtl/sd_read_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   - request vector
//   ptr   - index with highest priority this round
//   any   - at least one request set
//   grant - first set index at or after ptr, wrapping cyclically
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic             any,
    output logic [PTR_W-1:0] grant
);

    always_comb begin
        int idx;
        idx   = 0;
        any   = 1'b0;
        grant = '0;
        // Walk offsets from farthest to nearest so the nearest hit is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[PTR_W'(idx)]) begin
                any   = 1'b1;
                grant = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: shares one SD single-block-read (CMD17) engine among N_REQ
// requesters. Round-robin grant, latched engine address, level start held until
// done, then a mandatory low gap before the next grant. The read word returns to
// the winner with a registered one-cycle ack.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   bus         - sd_read_arbiter_if.slave (requester and engine signals)
// Optional build macro SD_READ_ARB_TIMEOUT_EN: adds a watchdog that aborts an
// ISSUE after TIMEOUT_CYCLES cycles with rsp_err=1. Without it rsp_err is 0 and
// ISSUE waits for rd_done indefinitely.
module sd_read_arbiter
    import sd_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              rst_n,
    sd_read_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (N_REQ < 2 || N_REQ > 8) begin : g_chk_n
        $error("N_REQ must be 2..8");
    end
    if (GAP_CYCLES < 1) begin : g_chk_gap
        $error("GAP_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_to
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    arb_state_t              state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        grant_q, grant_d;
    logic [SD_ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic                    rd_start_q, rd_start_d;
    logic [N_REQ-1:0]        ack_q, ack_d;
    logic [SD_DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic                    busy_q, busy_d;
    logic                    first_q, first_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
`ifdef SD_READ_ARB_TIMEOUT_EN
    logic                    rsp_err_q, rsp_err_d;
    logic [31:0]             to_cnt_q, to_cnt_d;
`endif

    logic                    pick_any;
    logic [PTR_W-1:0]        pick_idx;
    logic [SD_ADDR_W-1:0]    pick_addr;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .any   (pick_any),
        .grant (pick_idx)
    );

    // Address mux with constant part-selects only.
    always_comb begin
        pick_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == PTR_W'(i)) pick_addr = bus.req_addr[i*SD_ADDR_W +: SD_ADDR_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        rd_addr_d  = rd_addr_q;
        rd_start_d = rd_start_q;
        ack_d      = '0;
        rsp_data_d = rsp_data_q;
        first_d    = first_q;
        gap_cnt_d  = gap_cnt_q;
`ifdef SD_READ_ARB_TIMEOUT_EN
        rsp_err_d  = rsp_err_q;
        to_cnt_d   = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    rd_addr_d  = pick_addr;
                    rd_start_d = 1'b1;
                    first_d    = 1'b1;
                    state_d    = ISSUE;
`ifdef SD_READ_ARB_TIMEOUT_EN
                    to_cnt_d   = '0;
`endif
                end
            end
            ISSUE: begin
                first_d = 1'b0;
                // A done still high from the previous transaction is ignored
                // in the first ISSUE cycle.
                if (!first_q && bus.rd_done) begin
                    rsp_data_d     = bus.rd_data;
                    ack_d[grant_q] = 1'b1;
                    ptr_d          = (grant_q == PTR_W'(N_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
                    rd_start_d     = 1'b0;
                    gap_cnt_d      = '0;
                    state_d        = GAP;
`ifdef SD_READ_ARB_TIMEOUT_EN
                    rsp_err_d      = 1'b0;
                end else if (to_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    // Abort: keep the previous read word, flag the error.
                    ack_d[grant_q] = 1'b1;
                    rsp_err_d      = 1'b1;
                    ptr_d          = (grant_q == PTR_W'(N_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
                    rd_start_d     = 1'b0;
                    gap_cnt_d      = '0;
                    state_d        = GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
`endif
                end
            end
            GAP: begin
                if (gap_cnt_q != GAP_W'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end else if (!bus.rd_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            rd_addr_q  <= '0;
            rd_start_q <= 1'b0;
            ack_q      <= '0;
            rsp_data_q <= '0;
            busy_q     <= 1'b0;
            first_q    <= 1'b0;
            gap_cnt_q  <= '0;
`ifdef SD_READ_ARB_TIMEOUT_EN
            rsp_err_q  <= 1'b0;
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            rd_addr_q  <= rd_addr_d;
            rd_start_q <= rd_start_d;
            ack_q      <= ack_d;
            rsp_data_q <= rsp_data_d;
            busy_q     <= busy_d;
            first_q    <= first_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef SD_READ_ARB_TIMEOUT_EN
            rsp_err_q  <= rsp_err_d;
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    assign bus.ack      = ack_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.busy     = busy_q;
    assign bus.rd_start = rd_start_q;
    assign bus.rd_addr  = rd_addr_q;
`ifdef SD_READ_ARB_TIMEOUT_EN
    assign bus.rsp_err  = rsp_err_q;
`else
    assign bus.rsp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Directed bench for sd_read_arbiter with a behavioural single-block-read engine.
module tb_sd_read_arbiter;

    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int TO  = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_read_arbiter_if #(.N_REQ(N)) bus();

    sd_read_arbiter #(
        .N_REQ          (N),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Engine model: counts eng_delay negedges with rd_start high, then raises
    // done with eng_data; done falls eng_hold negedges after rd_start drops.
    logic        manual = 1'b0;
    logic        man_done = 1'b0;
    logic [31:0] man_data = '0;
    logic        eng_done = 1'b0;
    logic [31:0] eng_data = '0;
    logic [31:0] eng_rdata = '0;
    int          eng_delay = 10;
    int          eng_hold = 0;
    int          eng_cnt = 0;
    int          eng_hcnt = 0;

    assign bus.rd_done = manual ? man_done : eng_done;
    assign bus.rd_data = manual ? man_data : eng_rdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            eng_done = 1'b0; eng_cnt = 0; eng_hcnt = 0;
        end else if (bus.rd_start) begin
            eng_hcnt = 0;
            if (!eng_done && !manual) begin
                eng_cnt++;
                if (eng_cnt >= eng_delay) begin eng_done = 1'b1; eng_rdata = eng_data; end
            end
        end else begin
            eng_cnt = 0;
            if (eng_done) begin
                if (eng_hcnt >= eng_hold) eng_done = 1'b0;
                else eng_hcnt++;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; bus.req = '0; manual = 1'b0; man_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits up to max negedges for an ack; n = negedges waited (1-based).
    task automatic wait_ack(input int max, output logic [N-1:0] a, output bit to, output int n);
        to = 1'b1; a = '0; n = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.ack != '0) begin a = bus.ack; to = 1'b0; n = i + 1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.req = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.ack, bus.rsp_err, bus.busy, bus.rd_start} !== 7'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0", {bus.ack, bus.rsp_err, bus.busy, bus.rd_start});
        end
        n_cmp++;
        if (bus.rsp_data !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
        n_cmp++;
        if (bus.rd_addr !== 32'h0) begin n_bad++; $display("FAIL reset_rd_addr: got %h want 0", bus.rd_addr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [N-1:0] a; bit to; int n; int bad_addr;
        do_reset();
        eng_delay = 50; eng_hold = 0; eng_data = 32'hDEAD_BEEF;
        bus.req = 4'b0010;
        @(negedge clk);
        n_cmp++;
        if (bus.rd_start !== 1'b1) begin n_bad++; $display("FAIL single_start_latency: got %b want 1", bus.rd_start); end
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", bus.busy); end
        n_cmp++;
        if (bus.rd_addr !== 32'h0000_0200) begin n_bad++; $display("FAIL single_rd_addr: got %h want 00000200", bus.rd_addr); end
        bad_addr = 0; to = 1'b1; n = 0; a = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ack != '0) begin a = bus.ack; to = 1'b0; n = i + 1; break; end
            if (bus.rd_start && bus.rd_addr !== 32'h0000_0200) bad_addr++;
        end
        bus.req = '0;
        n_cmp++;
        if (to !== 1'b0) begin n_bad++; $display("FAIL single_ack_timeout: got none want ack"); end
        n_cmp++;
        if (bad_addr != 0) begin n_bad++; $display("FAIL single_addr_stable: got %0d bad cycles want 0", bad_addr); end
        n_cmp++;
        if (n != 50) begin n_bad++; $display("FAIL single_ack_latency: got %0d want 50", n); end
        n_cmp++;
        if (a !== 4'b0010) begin n_bad++; $display("FAIL single_ack: got %b want 0010", a); end
        n_cmp++;
        if (bus.rsp_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_rsp_data: got %h want deadbeef", bus.rsp_data); end
        n_cmp++;
        if (bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL single_rsp_err: got %b want 0", bus.rsp_err); end
        @(negedge clk);
        n_cmp++;
        if (bus.ack !== 4'b0000) begin n_bad++; $display("FAIL single_ack_pulse: got %b want 0000", bus.ack); end
        n_cmp++;
        if (bus.rsp_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_rsp_hold: got %h want deadbeef", bus.rsp_data); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [N-1:0] a; bit to; int n;
        logic [N-1:0] exp_a;
        do_reset();
        eng_delay = 5; eng_hold = 0;
        bus.req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            eng_data = 32'hA5A5_0000 + 32'(t);
            exp_a = 4'b0001 << (t % 4);
            wait_ack(100, a, to, n);
            n_cmp++;
            if (to !== 1'b0 || a !== exp_a) begin
                n_bad++; $display("FAIL fair_grant%0d: got %b want %b", t, a, exp_a);
            end
            n_cmp++;
            if (bus.rsp_data !== 32'hA5A5_0000 + 32'(t)) begin
                n_bad++; $display("FAIL fair_data%0d: got %h want %h", t, bus.rsp_data, 32'hA5A5_0000 + 32'(t));
            end
            @(negedge clk);
            n_cmp++;
            if (bus.ack !== 4'b0000) begin n_bad++; $display("FAIL fair_single_ack%0d: got %b want 0000", t, bus.ack); end
        end
        bus.req = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_gap();
        logic [N-1:0] a; bit to; int n; int low; bit prev_done; bit early;
        do_reset();
        eng_delay = 4; eng_hold = 3;
        bus.req = 4'b0001;
        for (int pass = 0; pass < 2; pass++) begin
            wait_ack(100, a, to, n);
            if (pass == 1) eng_hold = 0;
            low = 1; prev_done = bus.rd_done; early = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (bus.rd_start) begin early = prev_done; break; end
                low++; prev_done = bus.rd_done;
            end
            n_cmp++;
            if (to !== 1'b0 || low != ((pass == 0) ? 5 : 3)) begin
                n_bad++; $display("FAIL gap_low%0d: got %0d want %0d", pass, low, (pass == 0) ? 5 : 3);
            end
            n_cmp++;
            if (early !== 1'b0) begin n_bad++; $display("FAIL gap_regrant_done%0d: got regrant with done high want none", pass); end
        end
        bus.req = '0;
        wait_ack(100, a, to, n);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_stale_done();
        do_reset();
        manual = 1'b1; man_done = 1'b1; man_data = 32'h5151_0017;
        bus.req = 4'b0001;
        @(negedge clk);
        n_cmp++;
        if (bus.rd_start !== 1'b1) begin n_bad++; $display("FAIL stale_start: got %b want 1", bus.rd_start); end
        @(negedge clk);
        n_cmp++;
        if (bus.ack !== 4'b0000) begin n_bad++; $display("FAIL stale_first_cycle: got %b want 0000", bus.ack); end
        @(negedge clk);
        n_cmp++;
        if (bus.ack !== 4'b0001 || bus.rsp_data !== 32'h5151_0017) begin
            n_bad++; $display("FAIL stale_second_cycle: got %b/%h want 0001/51510017", bus.ack, bus.rsp_data);
        end
        bus.req = '0; man_done = 1'b0;
        repeat (6) @(negedge clk);
        manual = 1'b0;
    endtask

    task automatic test_withdraw();
        logic [N-1:0] a; bit to; int n;
        do_reset();
        eng_delay = 30; eng_hold = 0;
        bus.req = 4'b0011;
        @(negedge clk);
        n_cmp++;
        if (bus.rd_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL wd_first_addr: got %h want 00000100", bus.rd_addr); end
        repeat (10) @(negedge clk);
        bus.req = 4'b0010;
        wait_ack(100, a, to, n);
        n_cmp++;
        if (to !== 1'b0 || a !== 4'b0001) begin n_bad++; $display("FAIL wd_ack0: got %b want 0001", a); end
        wait_ack(100, a, to, n);
        n_cmp++;
        if (to !== 1'b0 || a !== 4'b0010) begin n_bad++; $display("FAIL wd_next_grant: got %b want 0010", a); end
        n_cmp++;
        if (bus.rd_addr !== 32'h0000_0200) begin n_bad++; $display("FAIL wd_next_addr: got %h want 00000200", bus.rd_addr); end
        bus.req = '0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] a; bit to; int n; int stray;
        do_reset();
        eng_delay = 20; eng_hold = 0;
        bus.req = 4'b0100;
        wait_ack(100, a, to, n);
        bus.req = '0;
        n_cmp++;
        if (to !== 1'b0 || a !== 4'b0100) begin n_bad++; $display("FAIL rm_pre_ack: got %b want 0100", a); end
        repeat (6) @(negedge clk);
        eng_delay = 50;
        bus.req = 4'b0100;
        @(negedge clk);
        n_cmp++;
        if (bus.rd_start !== 1'b1) begin n_bad++; $display("FAIL rm_start: got %b want 1", bus.rd_start); end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ack, bus.rsp_err, bus.busy, bus.rd_start} !== 7'b0 || bus.rd_addr !== 32'h0 || bus.rsp_data !== 32'h0) begin
            n_bad++; $display("FAIL rm_async_clear: got ctl=%b addr=%h data=%h want all 0",
                {bus.ack, bus.rsp_err, bus.busy, bus.rd_start}, bus.rd_addr, bus.rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1; bus.req = '0;
        stray = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.ack != '0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin n_bad++; $display("FAIL rm_no_ack: got %0d acks want 0", stray); end
        bus.req = 4'b1001;
        wait_ack(100, a, to, n);
        bus.req = '0;
        n_cmp++;
        if (to !== 1'b0 || a !== 4'b0001 || bus.rd_addr !== 32'h0000_0100) begin
            n_bad++; $display("FAIL rm_ptr_zero: got %b/%h want 0001/00000100", a, bus.rd_addr);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [N-1:0] a; bit to; int n;
        do_reset();
        eng_delay = 3; eng_hold = 0; eng_data = 32'h1234_5678;
        bus.req = 4'b0001;
        wait_ack(100, a, to, n);
        bus.req = '0;
        repeat (6) @(negedge clk);
        manual = 1'b1; man_done = 1'b0; man_data = 32'hFFFF_0000;
        bus.req = 4'b0001;
        @(negedge clk);
`ifdef SD_READ_ARB_TIMEOUT_EN
        wait_ack(300, a, to, n);
        bus.req = '0;
        n_cmp++;
        if (to !== 1'b0 || n != 100) begin n_bad++; $display("FAIL to_latency: got %0d want 100", n); end
        n_cmp++;
        if (a !== 4'b0001 || bus.rsp_err !== 1'b1) begin n_bad++; $display("FAIL to_ack_err: got %b/%b want 0001/1", a, bus.rsp_err); end
        n_cmp++;
        if (bus.rsp_data !== 32'h1234_5678) begin n_bad++; $display("FAIL to_data_kept: got %h want 12345678", bus.rsp_data); end
`else
        wait_ack(150, a, to, n);
        n_cmp++;
        if (to !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rd_start !== 1'b1) begin
            n_bad++; $display("FAIL noto_wait: got to=%b err=%b start=%b want 1/0/1", to, bus.rsp_err, bus.rd_start);
        end
        man_done = 1'b1;
        wait_ack(10, a, to, n);
        bus.req = '0; man_done = 1'b0;
        n_cmp++;
        if (to !== 1'b0 || a !== 4'b0001 || bus.rsp_data !== 32'hFFFF_0000) begin
            n_bad++; $display("FAIL noto_late_done: got %b/%h want 0001/ffff0000", a, bus.rsp_data);
        end
`endif
        repeat (6) @(negedge clk);
        manual = 1'b0;
    endtask

    initial begin
        bus.req = '0;
        for (int i = 0; i < N; i++) bus.req_addr[i*32 +: 32] = 32'((i + 1) * 256);
        test_reset();
        test_single();
        test_fairness();
        test_gap();
        test_stale_done();
        test_withdraw();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/sd_read_arbiter.md
Name: sd_read_arbiter

Overview:
- Shares one SD single-block-read engine (CMD17 path, level-held start/done handshake) among N_REQ requesters, e.g. sprite loader, audio streamer and level loader.
- Arbitrates round-robin and latches the winner's address.
- Sequences the engine's start line: held until done, then dropped for a mandatory gap.
- Returns the 32-bit read word to the winner with a one-cycle ack pulse.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 2, minimum cycles rd_start is held low between engine transactions (>=1).
- TIMEOUT_CYCLES, 1048576, watchdog limit on a single transaction (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester read request; level; held until ack.
- req_addr  in  N_REQ*32  flattened addresses; requester i uses bits [32*i+31:32*i].
- ack  out  N_REQ  one-hot one-cycle completion pulse.
- rsp_data  out  32  read word; valid in the ack cycle and held until the next ack.
- rsp_err  out  1  qualifies ack; 1 = transaction aborted (timeout).
- busy  out  1  high in any state other than IDLE.
- rd_start  out  1  engine start; level.
- rd_addr  out  32  engine address; stable while rd_start=1.
- rd_data  in  32  engine read word.
- rd_done  in  1  engine completion; level; falls after rd_start drops.

Behaviour:
- Reset values: ack=0, rsp_data=0, rsp_err=0, busy=0, rd_start=0, rd_addr=0, RR pointer=0, state=IDLE.
- States:
  - IDLE: if any req is set, grant the first set bit at or after ptr (cyclic). Latch grant index and rd_addr = winner's address. Go to ISSUE.
  - ISSUE: rd_start=1. On rd_done=1: capture rd_data into rsp_data, pulse ack[grant] with rsp_err=0, then go to GAP.
  - GAP: rd_start=0. Count GAP_CYCLES. Exit to IDLE only when the count has expired and rd_done=0.
- Round-robin: ptr = grant+1 (mod N_REQ), updated in the ack cycle.
- Latency: minimum 1 cycle from req to rd_start. Ack occurs in the cycle after rd_done is sampled high. Back-to-back grants are spaced by at least GAP_CYCLES+1 cycles.
- ack is combinational-free: it is a registered pulse of exactly one cycle.
- Requester drops req during ISSUE: the transaction still completes and ack still pulses. The requester ignores it.
- req still high in the cycle after its ack: treated as a new request, eligible under RR order.
- Simultaneous requests: lowest index at or after ptr wins. With ptr=2 and req=4'b1011, the winner is 3.
- rd_done high on entry to ISSUE (stale): ignored for the first ISSUE cycle. Completion is qualified from the second cycle.
- rd_addr is not updated outside IDLE-grant.
- Reset mid-operation: everything returns to reset values immediately. rd_start=0 lets the engine return to its halt state. No ack is issued for the aborted transaction.
- No starvation: every asserted req is served within N_REQ grants.

Optional Feature:
- Macro: SD_READ_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in ISSUE.
  - On reaching TIMEOUT_CYCLES-1 without rd_done: set rsp_err=1, leave rsp_data unchanged, pulse ack[grant], advance ptr, go to GAP.
  - The GAP exit still waits for rd_done=0 and GAP_CYCLES.
- Not defined: no counter logic, rsp_err is tied 0, and ISSUE waits indefinitely.

Decomposition:
- Package sd_pkg:
  - arb_state_t enum {IDLE, ISSUE, GAP}.
  - SD_CMD17 = 8'h51.
  - SD_ADDR_W = 32, SD_DATA_W = 32.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req vector and ptr.
  - Outputs: any and grant index.
- The top module owns the FSM, counters and registers.

Test Plan:
- Single request: req=4'b0010 with addr1=32'h0000_0200; engine model asserts done after 50 cycles with data 32'hDEAD_BEEF. Required: rd_addr=32'h200 while rd_start is high, then ack=4'b0010 with rsp_data=32'hDEADBEEF and rsp_err=0.
- Fairness: req=4'b1111 held for 8 transactions. Required grant order 0,1,2,3,0,1,2,3, with exactly one ack per transaction.
- Gap/handshake: engine holds done for 3 cycles after start drops. Required: rd_start stays 0 for max(GAP_CYCLES, done-low) cycles, and there is no regrant before rd_done=0.
- Withdrawn request: req0 drops 10 cycles into ISSUE. Required: the transaction completes, ack[0] pulses once, and the next grant goes to the other pending req.
- Reset mid-ISSUE: rst_n low for 1 cycle. Required: outputs return to reset values immediately, there is no ack, and a subsequent req0 is served normally from ptr=0.
- Timeout (SD_READ_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, engine never returns done). Required: ack fires 100 cycles after rd_start rises, with rsp_err=1 and rsp_data unchanged.
